clock_works: RTL and testbench

CLOCK_WORKS -- requirements
Module: clock_works

---
 rtl/clock_works_pkg.sv | 12 +
 rtl/reset_sync.sv | 36 +++
 rtl/clock_works.sv | 57 +++++
 tb/tb_clock_works.sv | 125 ++++++++++++
 4 files changed

// File: rtl/clock_works_pkg.sv
// rtl/clock_works_pkg.sv - shared default constants for the clock_works slice
// Purpose: holds the default division exponent and reset-synchronizer depth
//          used as parameter defaults by clock_works and reset_sync.
// Ports:   none (package).
package clock_works_pkg;

  // Default clock division exponent: clk period is 2^(SLOW+1) CLK cycles.
  localparam int SLOW_DEFAULT        = 21;
  // Default depth of the reset-release synchronizer chain.
  localparam int SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/reset_sync.sv
// rtl/reset_sync.sv - asynchronous-assert, synchronous-release reset synchronizer
// Purpose: produces an active-low reset that clears immediately with arst_n and
//          releases on the SYNC_STAGES-th rising clk edge after arst_n rises.
// Ports:
//   clk    input  1  clock of the destination domain
//   arst_n input  1  asynchronous active-low reset source
//   rst_n  output 1  synchronized active-low reset, driven straight from a flop
module reset_sync
  import clock_works_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic arst_n,
  output logic rst_n
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift a constant 1 in from the bottom; the top flop is the released reset.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rst_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clock_works.sv
// rtl/clock_works.sv - clock divider plus reset synchronizer for the divided domain
// Purpose: divides the board clock by 2^(SLOW+1) (or passes it through when
//          SLOW=0) and generates a matching reset for the divided clock domain.
// Ports:
//   CLK    input  1  board clock, the only clock input
//   RESETN input  1  asynchronous active-low board reset
//   clk    output 1  divided internal clock for downstream logic
//   resetn output 1  active-low reset for clk: async assert, sync release
module clock_works
  import clock_works_pkg::*;
#(
  parameter int SLOW        = SLOW_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic CLK,
  input  logic RESETN,
  output logic clk,
  output logic resetn
);

  generate
    if (SLOW >= 1) begin : g_div
      localparam int CNT_W = SLOW + 1;

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Free-running; natural modulo wrap from all-ones to zero.
      always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // Top counter bit comes straight off a flop, so clk is glitch-free
      // and exactly 50% duty.
      assign clk = cnt_q[SLOW];
    end else begin : g_pass
      assign clk = CLK;
    end
  endgenerate

  reset_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_reset_sync (
    .clk   (clk),
    .arst_n(RESETN),
    .rst_n (resetn)
  );

endmodule

// File: tb/tb_clock_works.sv
// tb/tb_clock_works.sv - randomized self-checking bench for clock_works
module tb_clock_works;

  logic       CLK;
  logic [2:0] rst;
  logic [2:0] clk_o;
  logic [2:0] rstn_o;

  int total = 0;
  int bad   = 0;

  // Instance 0: SLOW=2 SYNC=2, instance 1: SLOW=0 SYNC=2, instance 2: SLOW=3 SYNC=3
  int slow_of [3] = '{2, 0, 3};
  int sync_of [3] = '{2, 2, 3};
  int n       [3];            // CLK rising edges seen since RESETN last released
  int rises3;
  logic prev3;

  clock_works #(.SLOW(2), .SYNC_STAGES(2)) u_s2 (
    .CLK(CLK), .RESETN(rst[0]), .clk(clk_o[0]), .resetn(rstn_o[0])
  );
  clock_works #(.SLOW(0), .SYNC_STAGES(2)) u_s0 (
    .CLK(CLK), .RESETN(rst[1]), .clk(clk_o[1]), .resetn(rstn_o[1])
  );
  clock_works #(.SLOW(3), .SYNC_STAGES(3)) u_s3 (
    .CLK(CLK), .RESETN(rst[2]), .clk(clk_o[2]), .resetn(rstn_o[2])
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  // Level of clk while CLK is high, after n CLK edges since release.
  function automatic logic exp_clk(input int slow, input int cnt);
    if (slow == 0) return 1'b1;
    return 1'((cnt / (1 << slow)) % 2);
  endfunction

  // Number of clk rising edges produced by cnt CLK edges since release.
  function automatic int clk_rises(input int slow, input int cnt);
    if (slow == 0) return cnt;
    return (cnt + (1 << slow)) / (1 << (slow + 1));
  endfunction

  task automatic check_all(input string where);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s clk[%0d] n=%0d", where, i, n[i]), 32'(clk_o[i]),
               32'(exp_clk(slow_of[i], n[i])));
      check_eq($sformatf("%s resetn[%0d] n=%0d", where, i, n[i]), 32'(rstn_o[i]),
               32'(clk_rises(slow_of[i], n[i]) >= sync_of[i]));
    end
    check_eq($sformatf("%s cnt3 n=%0d", where, n[2]), 32'(u_s3.g_div.cnt_q), 32'(n[2] % 16));
  endtask

  // One CLK period: edge, sample, change resets mid-high-phase, sample again,
  // then confirm the SLOW=0 instance follows CLK low.
  task automatic cycle(input logic [2:0] new_rst);
    @(posedge CLK);
    for (int i = 0; i < 3; i++) if (rst[i]) n[i]++;
    #1;
    check_all("edge");
    if (clk_o[2] && !prev3) rises3++;
    prev3 = clk_o[2];
    #2;
    for (int i = 0; i < 3; i++) if (!new_rst[i]) n[i] = 0;
    rst = new_rst;
    #1;
    check_all("async");
    @(negedge CLK);
    #1;
    check_eq("clk[1] low phase", 32'(clk_o[1]), 32'd0);
  endtask

  initial begin
    logic [2:0] nr;
    rst = 3'b000;
    for (int i = 0; i < 3; i++) n[i] = 0;
    rises3 = 0;
    prev3  = 1'b0;
    #2;
    check_eq("reset clk[0]", 32'(clk_o[0]), 32'd0);
    check_eq("reset clk[2]", 32'(clk_o[2]), 32'd0);
    check_eq("reset resetn", 32'(rstn_o), 32'd0);
    cycle(3'b000);
    cycle(3'b000);
    cycle(3'b111);
    rises3 = 0;
    prev3  = clk_o[2];

    // 100 CLK cycles from release: divider timing, sync release, counter wrap.
    for (int k = 0; k < 100; k++) cycle(3'b111);
    check_eq("slow3 rises in 100", 32'(rises3), 32'd6);

    // SLOW=2 sits in its high phase after 100 edges: assert reset there.
    cycle(3'b110);
    cycle(3'b111);
    for (int k = 0; k < 20; k++) cycle(3'b111);

    // Pulse reset at edge 6 after a fresh release, before resetn releases.
    cycle(3'b110);
    cycle(3'b111);
    for (int k = 0; k < 5; k++) cycle(3'b111);
    cycle(3'b110);
    cycle(3'b111);
    for (int k = 0; k < 20; k++) cycle(3'b111);

    // Randomized reset activity on all three instances.
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < 3; i++)
        nr[i] = rst[i] ? ($urandom_range(0, 39) != 0) : ($urandom_range(0, 2) == 0);
      cycle(nr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
